coef_node_bank: RTL and testbench

//  Per-node coefficient register bank: the receiving and sending end of the control unit's coefficient protocol.

---
 rtl/coef_node_bank.sv | 129 ++++++++++++
 tb/tb_coef_node_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/coef_node_bank.sv
// Per-node coefficient bank: serial load from the coefficient bus, parallel backprop update,
// and a registered serial save pass back onto the bus (1-cycle latency, no gap between passes).
module coef_node_bank #(
  parameter int NIN = 2,
  parameter int N   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         bus_in,
  input  logic                 c_we,
  input  logic                 upd_we,
  input  logic [(NIN+1)*N-1:0] upd_data,
  input  logic                 sv_en,
  input  logic                 dtb,
  output logic [(NIN+1)*N-1:0] coef,
  output logic [N-1:0]         bus_out,
  output logic                 bus_oe,
  output logic                 loaded,
  output logic                 sv_done,
  output logic                 err
);

  localparam int K  = NIN + 1;
  localparam int CW = $clog2(K + 1);
  localparam int PW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  logic [N-1:0]  coef_q [K];
  logic [N-1:0]  coef_d [K];
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          loaded_q, loaded_d;
  logic          err_q, err_d;

  state_t        state_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_idx;
  logic [N-1:0]  rd_word;
  logic          rd_last;
  logic [N-1:0]  bus_out_q;
  logic          bus_oe_q;
  logic          sv_done_q;

  // Load has priority over a same-cycle update; the collision only counts in update mode.
  always_comb begin
    coef_d   = coef_q;
    wr_cnt_d = wr_cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (c_we) begin
      if (wr_cnt_q < CW'(K)) begin
        for (int j = 0; j < K; j++) begin
          if (wr_cnt_q == CW'(j)) coef_d[j] = bus_in;
        end
        wr_cnt_d = wr_cnt_q + CW'(1);
        loaded_d = (wr_cnt_q == CW'(K - 1));
      end else begin
        err_d = 1'b1;
      end
      if (upd_we && !dtb) err_d = 1'b1;
    end else begin
      wr_cnt_d = '0;
      if (upd_we && !dtb) begin
        for (int j = 0; j < K; j++) coef_d[j] = upd_data[j*N +: N];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < K; j++) coef_q[j] <= '0;
      wr_cnt_q <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int j = 0; j < K; j++) coef_q[j] <= coef_d[j];
      wr_cnt_q <= wr_cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // A pass starting from IDLE drives word 0 on the same edge, giving 1-cycle latency.
  always_comb begin
    rd_idx  = (state_q == S_DRIVE) ? rd_ptr_q : '0;
    rd_word = '0;
    for (int j = 0; j < K; j++) begin
      if (rd_idx == PW'(j)) rd_word = coef_q[j];
    end
    rd_last = (rd_idx == PW'(K - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      bus_out_q <= '0;
      bus_oe_q  <= 1'b0;
      sv_done_q <= 1'b0;
    end else if (sv_en && dtb) begin
      bus_out_q <= rd_word;
      bus_oe_q  <= 1'b1;
      sv_done_q <= rd_last;
      if (rd_last) begin
        rd_ptr_q <= '0;
        state_q  <= S_IDLE;
      end else begin
        rd_ptr_q <= rd_idx + PW'(1);
        state_q  <= S_DRIVE;
      end
    end else begin
      bus_oe_q  <= 1'b0;
      sv_done_q <= 1'b0;
      rd_ptr_q  <= '0;
      state_q   <= S_IDLE;
    end
  end

  always_comb begin
    for (int j = 0; j < K; j++) coef[j*N +: N] = coef_q[j];
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign loaded  = loaded_q;
  assign sv_done = sv_done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_coef_node_bank.sv
// Bench for coef_node_bank: directed protocol scenarios followed by random traffic,
// all checked cycle by cycle against a word-array reference model.
module tb_coef_node_bank;

  localparam int NIN = 2;
  localparam int N   = 16;
  localparam int K   = NIN + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   bus_in;
  logic           c_we;
  logic           upd_we;
  logic [K*N-1:0] upd_data;
  logic           sv_en;
  logic           dtb;
  logic [K*N-1:0] coef;
  logic [N-1:0]   bus_out;
  logic           bus_oe;
  logic           loaded;
  logic           sv_done;
  logic           err;

  coef_node_bank #(.NIN(NIN), .N(N)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .c_we(c_we), .upd_we(upd_we),
    .upd_data(upd_data), .sv_en(sv_en), .dtb(dtb), .coef(coef), .bus_out(bus_out),
    .bus_oe(bus_oe), .loaded(loaded), .sv_done(sv_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [N-1:0] m_c [K];
  int           m_wcnt;
  int           m_pos;
  bit           m_ld, m_er, m_oe, m_done;
  logic [N-1:0] m_bo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [K*N-1:0] m_pack();
    logic [K*N-1:0] v;
    for (int j = 0; j < K; j++) v[j*N +: N] = m_c[j];
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < K; j++) m_c[j] = '0;
    m_wcnt = 0; m_pos = 0; m_ld = 0; m_er = 0; m_oe = 0; m_done = 0; m_bo = '0;
  endtask

  // One clock edge of the protocol; the save reads coefficients as they were before the edge.
  task automatic model_clk();
    if (sv_en && dtb) begin
      m_bo   = m_c[m_pos];
      m_oe   = 1;
      m_done = (m_pos == K - 1);
      m_pos  = m_done ? 0 : m_pos + 1;
    end else begin
      m_oe = 0; m_done = 0; m_pos = 0;
    end
    if (c_we) begin
      if (m_wcnt < K) begin
        m_c[m_wcnt] = bus_in;
        m_wcnt++;
        m_ld = (m_wcnt == K);
      end else begin
        m_er = 1;
      end
      if (upd_we && !dtb) m_er = 1;
    end else begin
      m_wcnt = 0;
      if (upd_we && !dtb)
        for (int j = 0; j < K; j++) m_c[j] = upd_data[j*N +: N];
    end
  endtask

  task automatic check_all();
    chk("coef", 64'(coef), 64'(m_pack()));
    chk("bus_oe", 64'(bus_oe), 64'(m_oe));
    if (m_oe) chk("bus_out", 64'(bus_out), 64'(m_bo));
    chk("loaded", 64'(loaded), 64'(m_ld));
    chk("sv_done", 64'(sv_done), 64'(m_done));
    chk("err", 64'(err), 64'(m_er));
  endtask

  task automatic idle_inputs();
    bus_in = '0; c_we = 0; upd_we = 0; upd_data = '0; sv_en = 0; dtb = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #2;
    model_reset();
    check_all();
    chk("rst_bus_out", 64'(bus_out), 64'(0));
    @(negedge clk);
    rst = 1;
  endtask

  task automatic load3(input logic [N-1:0] w0, input logic [N-1:0] w1, input logic [N-1:0] w2);
    logic [N-1:0] w [K];
    w[0] = w0; w[1] = w1; w[2] = w2;
    for (int i = 0; i < K; i++) begin
      c_we = 1; bus_in = w[i];
      step();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #3;
    do_reset();

    // Basic load
    load3(16'h0100, 16'h0200, 16'h0080);
    chk("load_coef", 64'(coef), 64'h0080_0200_0100);
    chk("load_loaded", 64'(loaded), 64'(1));
    chk("load_err", 64'(err), 64'(0));
    step();

    // Save pass
    dtb = 1;
    for (int i = 0; i < K; i++) begin
      sv_en = 1;
      step();
      chk("save_oe", 64'(bus_oe), 64'(1));
      chk("save_done", 64'(sv_done), 64'(i == K - 1));
    end
    chk("save_last", 64'(bus_out), 64'h0080);
    idle_inputs();
    step();
    chk("save_oe_off", 64'(bus_oe), 64'(0));

    // Parallel update
    upd_we = 1; upd_data = 48'h0001_0002_0003;
    step();
    chk("upd_coef", 64'(coef), 64'h0001_0002_0003);
    chk("upd_err", 64'(err), 64'(0));

    // Update colliding with load
    upd_data = 48'h0004_0005_0006; c_we = 1; bus_in = 16'h0abc;
    step();
    chk("coll_coef", 64'(coef), 64'h0001_0002_0abc);
    chk("coll_err", 64'(err), 64'(1));
    idle_inputs();
    step();

    // Overflow on 4th load word
    do_reset();
    for (int i = 0; i < K + 1; i++) begin
      c_we = 1; bus_in = 16'h1000 + 16'(i);
      step();
    end
    chk("ovf_coef", 64'(coef), 64'h1002_1001_1000);
    chk("ovf_err", 64'(err), 64'(1));
    idle_inputs();
    step();

    // Reset mid-save, then a fresh load and save from word 0
    do_reset();
    load3(16'h0011, 16'h0022, 16'h0033);
    dtb = 1; sv_en = 1;
    step();
    step();
    chk("mid_w1", 64'(bus_out), 64'h0022);
    @(negedge clk);
    do_reset();
    chk("mid_rst_oe", 64'(bus_oe), 64'(0));
    chk("mid_rst_coef", 64'(coef), 64'(0));
    load3(16'h0044, 16'h0055, 16'h0066);
    dtb = 1; sv_en = 1;
    step();
    chk("restart_w0", 64'(bus_out), 64'h0044);

    // Abort after word 0
    sv_en = 0;
    step();
    chk("abort_oe", 64'(bus_oe), 64'(0));
    chk("abort_done", 64'(sv_done), 64'(0));
    sv_en = 1;
    step();
    chk("after_abort_w0", 64'(bus_out), 64'h0044);
    idle_inputs();
    step();

    // Random traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      c_we     = ($urandom_range(0, 9) < 5);
      dtb      = ($urandom_range(0, 9) < 4);
      sv_en    = ($urandom_range(0, 9) < 7);
      upd_we   = !dtb && ($urandom_range(0, 3) == 0);
      bus_in   = N'($urandom);
      upd_data = {N'($urandom), N'($urandom), N'($urandom)};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
